// File: rtl/video_frame_scheduler.sv
// video_frame_scheduler
//
// Sequences multi-frame runs through the stream source -> processing core -> BMP sink chain.
// Each frame: pulse src_begin for BEGIN_LEN cycles, then wait until the source reports
// done and the processed stream has closed the frame (a vsync rising edge after at least
// one valid pixel). Frames are separated by GAP_LEN idle cycles. A watchdog moves to an
// error state if post_valid stays low for TIMEOUT cycles while a frame is running.
//
// Optional feature macro: SCHED_PIXCHK_EN
//   When defined, post_valid is counted per frame and err_pixcnt is set (sticky) whenever a
//   completed frame did not carry exactly H_DISP*V_DISP pixels. When undefined, err_pixcnt
//   is tied low and no counter is built.
//
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   start        1-cycle pulse, begins a run from IDLE/DONE/ERR
//   abort        1-cycle pulse, returns to IDLE from any state (wins over start)
//   src_begin    begin strobe to the stream source
//   src_done     source finished reading the current frame (level or pulse)
//   post_vsync   processed-stream vsync, active high
//   post_valid   processed-stream pixel valid
//   busy         run in progress (LAUNCH/RUN/GAP)
//   run_done     1-cycle pulse when the last frame of a run completes
//   frame_cnt    frames completed in the current run
//   err_timeout  sticky watchdog error, cleared by start
//   err_pixcnt   sticky pixel-count error, cleared by start

module video_frame_scheduler #(
  parameter logic [15:0] FRAMES    = 16'd4,
  parameter logic [7:0]  BEGIN_LEN = 8'd5,
  parameter logic [15:0] GAP_LEN   = 16'd64,
  parameter logic [23:0] TIMEOUT   = 24'd2000000,
  parameter logic [10:0] H_DISP    = 11'd800,
  parameter logic [10:0] V_DISP    = 11'd600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        src_begin,
  input  logic        src_done,
  input  logic        post_vsync,
  input  logic        post_valid,
  output logic        busy,
  output logic        run_done,
  output logic [15:0] frame_cnt,
  output logic        err_timeout,
  output logic        err_pixcnt
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLaunch = 3'd1;
  localparam logic [2:0] StRun    = 3'd2;
  localparam logic [2:0] StGap    = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;
  localparam logic [2:0] StErr    = 3'd5;

  // Registered copies of the inputs; all decisions use these.
  logic start_q, abort_q, src_done_q, post_vsync_q, vsync_prev_q, post_valid_q;
  logic vs_rise;

  logic [2:0]  state_q, state_d;
  logic [7:0]  begin_cnt_q, begin_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [23:0] wd_cnt_q, wd_cnt_d;
  logic        got_done_q, got_done_d;
  logic        got_pix_q, got_pix_d;
  logic        got_end_q, got_end_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        src_begin_q, src_begin_d;
  logic        busy_q, busy_d;
  logic        run_done_q, run_done_d;
  logic        err_timeout_q, err_timeout_d;
  logic        frame_complete;
  logic        clear_errs;

  assign vs_rise = post_vsync_q & ~vsync_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q      <= 1'b0;
      abort_q      <= 1'b0;
      src_done_q   <= 1'b0;
      post_vsync_q <= 1'b0;
      vsync_prev_q <= 1'b0;
      post_valid_q <= 1'b0;
    end else begin
      start_q      <= start;
      abort_q      <= abort;
      src_done_q   <= src_done;
      post_vsync_q <= post_vsync;
      vsync_prev_q <= post_vsync_q;
      post_valid_q <= post_valid;
    end
  end

  always_comb begin
    state_d        = state_q;
    begin_cnt_d    = '0;
    gap_cnt_d      = '0;
    wd_cnt_d       = wd_cnt_q;
    got_done_d     = got_done_q;
    got_pix_d      = got_pix_q;
    got_end_d      = got_end_q;
    frame_cnt_d    = frame_cnt_q;
    err_timeout_d  = err_timeout_q;
    frame_complete = 1'b0;
    clear_errs     = 1'b0;

    if (abort_q) begin
      // Abort wins over everything, including a start in the same cycle.
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StDone, StErr: begin
          if (start_q) begin
            state_d       = StLaunch;
            frame_cnt_d   = '0;
            err_timeout_d = 1'b0;
            clear_errs    = 1'b1;
          end
        end
        StLaunch: begin
          got_done_d = 1'b0;
          got_pix_d  = 1'b0;
          got_end_d  = 1'b0;
          wd_cnt_d   = '0;
          if (begin_cnt_q >= BEGIN_LEN - 8'd1) begin
            state_d = StRun;
          end else begin
            begin_cnt_d = begin_cnt_q + 8'd1;
          end
        end
        StRun: begin
          got_done_d = got_done_q | src_done_q;
          got_pix_d  = got_pix_q | post_valid_q;
          // The vsync edge that opens a frame arrives before any pixel and is ignored.
          got_end_d  = got_end_q | (vs_rise & got_pix_q);
          if (post_valid_q) begin
            wd_cnt_d = '0;
          end else if (wd_cnt_q != '1) begin
            wd_cnt_d = wd_cnt_q + 24'd1;
          end
          if (got_done_d && got_end_d) begin
            frame_complete = 1'b1;
            if (frame_cnt_q != '1) begin
              frame_cnt_d = frame_cnt_q + 16'd1;
            end
            if (frame_cnt_d == FRAMES) begin
              state_d = StDone;
            end else if (GAP_LEN == 16'd0) begin
              state_d = StLaunch;
            end else begin
              state_d = StGap;
            end
          end else if (wd_cnt_d >= TIMEOUT) begin
            state_d       = StErr;
            err_timeout_d = 1'b1;
          end
        end
        StGap: begin
          if (gap_cnt_q != '1) begin
            gap_cnt_d = gap_cnt_q + 16'd1;
          end
          if (gap_cnt_q >= GAP_LEN - 16'd1) begin
            state_d   = StLaunch;
            gap_cnt_d = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Outputs are registered from the next state so they change cleanly on the clock edge.
    src_begin_d = (state_d == StLaunch);
    busy_d      = (state_d == StLaunch) || (state_d == StRun) || (state_d == StGap);
    run_done_d  = (state_d == StDone) && (state_q != StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      begin_cnt_q   <= '0;
      gap_cnt_q     <= '0;
      wd_cnt_q      <= '0;
      got_done_q    <= 1'b0;
      got_pix_q     <= 1'b0;
      got_end_q     <= 1'b0;
      frame_cnt_q   <= '0;
      src_begin_q   <= 1'b0;
      busy_q        <= 1'b0;
      run_done_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      begin_cnt_q   <= begin_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
      got_done_q    <= got_done_d;
      got_pix_q     <= got_pix_d;
      got_end_q     <= got_end_d;
      frame_cnt_q   <= frame_cnt_d;
      src_begin_q   <= src_begin_d;
      busy_q        <= busy_d;
      run_done_q    <= run_done_d;
      err_timeout_q <= err_timeout_d;
    end
  end

`ifdef SCHED_PIXCHK_EN
  localparam logic [21:0] PixTarget = 22'(H_DISP) * 22'(V_DISP);

  logic [19:0] pix_cnt_q, pix_cnt_d;
  logic        err_pixcnt_q, err_pixcnt_d;

  always_comb begin
    pix_cnt_d    = pix_cnt_q;
    err_pixcnt_d = err_pixcnt_q;
    if (state_q == StLaunch) begin
      pix_cnt_d = '0;
    end else if (state_q == StRun && post_valid_q && pix_cnt_q != '1) begin
      pix_cnt_d = pix_cnt_q + 20'd1;
    end
    // The completing cycle's own pixel is included via pix_cnt_d.
    if (clear_errs) begin
      err_pixcnt_d = 1'b0;
    end else if (frame_complete && ({2'b00, pix_cnt_d} != PixTarget)) begin
      err_pixcnt_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_q    <= '0;
      err_pixcnt_q <= 1'b0;
    end else begin
      pix_cnt_q    <= pix_cnt_d;
      err_pixcnt_q <= err_pixcnt_d;
    end
  end

  assign err_pixcnt = err_pixcnt_q;
`else
  logic unused_pixchk;
  assign unused_pixchk = ^{H_DISP, V_DISP, frame_complete, clear_errs};
  assign err_pixcnt    = 1'b0;
`endif

  assign src_begin   = src_begin_q;
  assign busy        = busy_q;
  assign run_done    = run_done_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_video_frame_scheduler.sv
module tb_video_frame_scheduler;

  // Small picture and short timings keep the run short.
  localparam int FR  = 3;
  localparam int BL  = 5;
  localparam int GL  = 16;
  localparam int TO  = 100;
  localparam int PIX = 12;  // 4 x 3

  localparam int M_IDLE = 0, M_LAUNCH = 1, M_RUN = 2, M_GAP = 3, M_DONE = 4, M_ERR = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, src_done = 1'b0, post_vsync = 1'b0, post_valid = 1'b0;
  logic        src_begin, busy, run_done, err_timeout, err_pixcnt;
  logic [15:0] frame_cnt;

  video_frame_scheduler #(
    .FRAMES   (16'd3),
    .BEGIN_LEN(8'd5),
    .GAP_LEN  (16'd16),
    .TIMEOUT  (24'd100),
    .H_DISP   (11'd4),
    .V_DISP   (11'd3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .src_begin  (src_begin),
    .src_done   (src_done),
    .post_vsync (post_vsync),
    .post_valid (post_valid),
    .busy       (busy),
    .run_done   (run_done),
    .frame_cnt  (frame_cnt),
    .err_timeout(err_timeout),
    .err_pixcnt (err_pixcnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_mode, m_left, m_quiet, m_frames, m_pixn;
  bit m_done, m_pix, m_end, m_rd, m_eto, m_epix;
  bit r_start, r_abort, r_done, r_vs, r_vs_prev, r_valid;

  task automatic model_reset();
    m_mode = M_IDLE; m_left = 0; m_quiet = 0; m_frames = 0; m_pixn = 0;
    m_done = 0; m_pix = 0; m_end = 0; m_rd = 0; m_eto = 0; m_epix = 0;
    r_start = 0; r_abort = 0; r_done = 0; r_vs = 0; r_vs_prev = 0; r_valid = 0;
  endtask

  task automatic model_launch();
    m_mode = M_LAUNCH; m_left = BL;
    m_done = 0; m_pix = 0; m_end = 0; m_quiet = 0; m_pixn = 0;
  endtask

  task automatic model_step();
    bit vs_rise;
    vs_rise = r_vs && !r_vs_prev;
    m_rd = 0;
    if (r_abort) begin
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE, M_DONE, M_ERR: begin
          if (r_start) begin
            m_frames = 0; m_eto = 0; m_epix = 0;
            model_launch();
          end
        end
        M_LAUNCH: begin
          m_left--;
          if (m_left == 0) m_mode = M_RUN;
        end
        M_RUN: begin
          if (r_done) m_done = 1;
          if (vs_rise && m_pix) m_end = 1;
          if (r_valid) begin
            m_pix = 1; m_pixn++; m_quiet = 0;
          end else begin
            m_quiet++;
          end
          if (m_done && m_end) begin
            m_frames++;
`ifdef SCHED_PIXCHK_EN
            if (m_pixn != PIX) m_epix = 1;
`endif
            if (m_frames == FR) begin
              m_mode = M_DONE; m_rd = 1;
            end else if (GL == 0) begin
              model_launch();
            end else begin
              m_mode = M_GAP; m_left = GL;
            end
          end else if (m_quiet >= TO) begin
            m_mode = M_ERR; m_eto = 1;
          end
        end
        M_GAP: begin
          m_left--;
          if (m_left == 0) model_launch();
        end
        default: m_mode = M_IDLE;
      endcase
    end
    r_vs_prev = r_vs;
    r_start = start; r_abort = abort; r_done = src_done; r_vs = post_vsync; r_valid = post_valid;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- compare + event monitor ----------------
  int n_begin = 0, n_rd = 0, blen = 0;
  int unsigned begin_rise[64];
  int unsigned inc_time[64];
  logic prev_begin = 1'b0;
  logic [15:0] prev_fc = '0;

  initial begin
    forever begin
      @(negedge clk);
      chk("src_begin", int'(src_begin), int'(m_mode == M_LAUNCH));
      chk("busy", int'(busy), int'(m_mode == M_LAUNCH || m_mode == M_RUN || m_mode == M_GAP));
      chk("run_done", int'(run_done), int'(m_rd));
      chk("frame_cnt", int'(frame_cnt), m_frames);
      chk("err_timeout", int'(err_timeout), int'(m_eto));
      chk("err_pixcnt", int'(err_pixcnt), int'(m_epix));
      if (src_begin && !prev_begin) begin
        begin_rise[n_begin % 64] = cyc_n;
        n_begin++;
        blen = 0;
      end
      if (src_begin) blen++;
      if (!src_begin && prev_begin && rst_n) chk("begin_len", blen, 5);
      if (run_done) n_rd++;
      if (frame_cnt != prev_fc && frame_cnt != 16'd0) inc_time[frame_cnt % 64] = cyc_n;
      prev_begin = src_begin;
      prev_fc = frame_cnt;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic wait_begin(input logic lvl, input string what);
    int n;
    n = 0;
    while (src_begin !== lvl && n < 300) begin cyc(); n++; end
    if (src_begin !== lvl) begin
      total++; bad++;
      $display("FAIL %s: src_begin never reached %0d within 300 cycles", what, lvl);
    end
  endtask

  task automatic wait_idle(input string what);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 400) begin cyc(); n++; end
    if (busy !== 1'b0) begin
      total++; bad++;
      $display("FAIL %s: busy still high after 400 cycles", what);
    end
  endtask

  // order 0: done then closing vsync; 1: vsync then done; 2: both in the same cycle
  task automatic do_frame(input int nvalid, input int order);
    wait_begin(1'b1, "frame_begin_rise");
    wait_begin(1'b0, "frame_begin_fall");
    if (order == 1) begin start = 1'b1; cyc(); start = 1'b0; end  // ignored while busy
    post_vsync = 1'b1; cyc(); cyc(); post_vsync = 1'b0;            // leading vsync
    for (int i = 0; i < nvalid; i++) begin post_valid = 1'b1; cyc(); end
    post_valid = 1'b0; cyc(); cyc();
    case (order)
      0: begin
        src_done = 1'b1; cyc(); src_done = 1'b0; cyc(); cyc(); cyc();
        post_vsync = 1'b1; cyc(); cyc(); post_vsync = 1'b0;
      end
      1: begin
        post_vsync = 1'b1; cyc(); cyc(); post_vsync = 1'b0; cyc(); cyc();
        src_done = 1'b1; cyc(); src_done = 1'b0;
      end
      default: begin
        post_vsync = 1'b1; src_done = 1'b1; cyc(); src_done = 1'b0; cyc(); post_vsync = 1'b0;
      end
    endcase
    cyc(); cyc(); cyc();
  endtask

  int b0, r0, b1;
  int unsigned t0;

  initial begin
    repeat (3) cyc();
    chk("rst_src_begin", int'(src_begin), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_run_done", int'(run_done), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_err_timeout", int'(err_timeout), 0);
    chk("rst_err_pixcnt", int'(err_pixcnt), 0);
    rst_n = 1'b1; cyc(); cyc();

    // Three-frame run covering all three completion orders.
    b0 = n_begin; r0 = n_rd;
    pulse_start();
    do_frame(PIX, 0);
    do_frame(PIX, 1);
    do_frame(PIX, 2);
    wait_idle("run1");
    cyc();
    chk("run1_begins", n_begin - b0, 3);
    chk("run1_done_pulses", n_rd - r0, 1);
    chk("run1_frames", int'(frame_cnt), 3);
    chk("run1_busy", int'(busy), 0);
    chk("run1_pixerr", int'(err_pixcnt), 0);
    // Next src_begin rises exactly GAP_LEN cycles after frame_cnt steps.
    chk("gap_1_2", int'(begin_rise[(b0 + 1) % 64] - inc_time[1]), 16);
    chk("gap_2_3", int'(begin_rise[(b0 + 2) % 64] - inc_time[2]), 16);

    // Watchdog: pixels stop mid-frame.
    pulse_start();
    wait_begin(1'b1, "t4_begin_rise");
    wait_begin(1'b0, "t4_begin_fall");
    repeat (3) begin post_valid = 1'b1; cyc(); end
    post_valid = 1'b0;
    t0 = cyc_n;
    for (int n = 0; n < 300 && err_timeout !== 1'b1; n++) cyc();
    // input register stage + TIMEOUT quiet cycles
    chk("timeout_latency", int'(cyc_n - t0), 101);
    chk("timeout_err", int'(err_timeout), 1);
    chk("timeout_busy", int'(busy), 0);
    chk("timeout_frames", int'(frame_cnt), 0);
    pulse_start();
    cyc(); cyc();
    chk("restart_clears_err", int'(err_timeout), 0);
    chk("restart_busy", int'(busy), 1);

    // Abort and start together during RUN.
    wait_begin(1'b0, "t5_run");
    post_valid = 1'b1; cyc(); cyc(); post_valid = 1'b0;
    b1 = n_begin;
    start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
    repeat (40) cyc();
    chk("abort_busy", int'(busy), 0);
    chk("abort_no_begin", n_begin - b1, 0);
    chk("abort_src_begin", int'(src_begin), 0);

    // Reset in the middle of LAUNCH drops src_begin immediately.
    pulse_start();
    wait_begin(1'b1, "t5_launch");
    cyc();
    rst_n = 1'b0;
    #1;
    chk("rstmid_src_begin", int'(src_begin), 0);
    chk("rstmid_busy", int'(busy), 0);
    repeat (3) cyc();
    rst_n = 1'b1; cyc();

    // First frame one pixel short.
    r0 = n_rd;
    pulse_start();
    do_frame(PIX - 1, 0);
    do_frame(PIX, 1);
    do_frame(PIX, 2);
    wait_idle("run_pix");
    cyc();
    chk("pix_run_done", n_rd - r0, 1);
    chk("pix_frames", int'(frame_cnt), 3);
`ifdef SCHED_PIXCHK_EN
    chk("pix_err", int'(err_pixcnt), 1);
`else
    chk("pix_err", int'(err_pixcnt), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "bench time limit reached");
  end

endmodule
